// File: rtl/stack_pkg.sv
// Shared definitions for the recursion stack: operation and FSM encodings,
// default geometry, and small decode helpers used by the arbiter.
package stack_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_TOP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // An operation errors when it cannot be carried out against the current
  // occupancy; the unused 00 encoding always errors.
  function automatic logic op_err(input op_t op, input logic full, input logic empty);
    case (op)
      OP_PUSH:        return full;
      OP_POP, OP_TOP: return empty;
      default:        return 1'b1;
    endcase
  endfunction

  // Two-client round-robin: on contention the client not served last wins,
  // otherwise the single requester wins. Returns the granted client index.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Client-facing bus of the stack arbiter: two request/ack clients, a flush
// line and the shared status outputs.
//
// Handshake: a client raises req[i] with op/wdata and holds all three stable
// until it sees ack[i] high (a single-cycle pulse); it drops req[i] on the
// following cycle. rdata and err belong to the completing operation and are
// valid while ack is high. flush is a level request, held until empty=1.
interface stack_arbiter_if #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic [1:0]        req;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output flush, req, op0, op1, wdata0, wdata1,
    input  ack, rdata, err, count, full, empty
  );

  modport slave (
    input  flush, req, op0, op1, wdata0, wdata1,
    output ack, rdata, err, count, full, empty
  );

endinterface

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W registers, one synchronous write port and
// one asynchronous read port. Contents are not reset.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Two-client stack arbiter. Each request is served in three steps: IDLE
// grants and latches the request, EXEC operates on the stack, RESP pulses
// the client's ack. DEPTH must be a power of two, at least 2, so that the
// low bits of count address the storage directly.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus,
  output state_t         state_dbg
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              empty;
  logic [1:0]        req_eff;
  logic              pick;
  logic              exec_err;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A client whose ack is on the bus right now still holds req for one more
  // cycle; masking it keeps one request from being served twice.
  assign req_eff  = bus.req & ~ack_q;
  assign pick     = rr_pick(req_eff, last_q);
  assign exec_err = op_err(op_q, full, empty);

  // Top of stack sits at count-1; wraps correctly when count == DEPTH.
  assign mem_waddr = count_q[AW-1:0];
  assign mem_raddr = count_q[AW-1:0] - 1'b1;

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wdata_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // State and datapath registers; reset leaves client 1 as last served so
  // client 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      op_q    <= OP_ILL;
      wdata_q <= '0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath decode for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    ack_d   = 2'b00;
    err_d   = err_q;
    rdata_d = rdata_q;
    count_d = count_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          // Clear occupancy only; storage keeps its contents.
          count_d = '0;
        end else if (req_eff != 2'b00) begin
          grant_d = pick;
          op_d    = pick ? op_t'(bus.op1) : op_t'(bus.op0);
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_RESP;
        err_d   = exec_err;
        rdata_d = '0;
        if (!exec_err) begin
          case (op_q)
            OP_PUSH: begin
              mem_we  = 1'b1;
              count_d = count_q + 1'b1;
            end
            OP_POP: begin
              rdata_d = mem_rdata;
              count_d = count_q - 1'b1;
            end
            OP_TOP: begin
              rdata_d = mem_rdata;
            end
            default: begin
            end
          endcase
        end
      end

      ST_RESP: begin
        ack_d[grant_q] = 1'b1;
        last_d         = grant_q;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter with DEPTH=4: table of single-client operations,
// randomized operations against a stack model, round-robin contention,
// flush with a pending request, and reset in the middle of an operation.
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int EXP_W = 2 + DW + 1 + 3;

  typedef struct {
    int          c;
    logic [1:0]  op;
    logic [DW-1:0] d;
    logic [DW-1:0] er;
    logic        ee;
    int          ec;
  } vec_t;

  logic   clk;
  logic   rst;
  state_t state_dbg;

  stack_arbiter_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  stack_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  logic             got_ack;
  logic [EXP_W-1:0] exp_q[$];
  vec_t             tbl [17];
  logic [DW-1:0]    mm [DEPTH];
  int               mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample after the edge and score any ack against the queue.
  task automatic step();
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ack !== 2'b00) begin
      got_ack = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack",   32'(bus.ack),   32'(e[EXP_W-1 -: 2]));
        check("rdata", 32'(bus.rdata), 32'(e[DW+3:4]));
        check("err",   32'(bus.err),   32'(e[3]));
        check("count", 32'(bus.count), 32'(e[2:0]));
        check("full",  32'(bus.full),  32'(e[2:0] == 3'd4));
        check("empty", 32'(bus.empty), 32'(e[2:0] == 3'd0));
      end
    end
  endtask

  task automatic wait_ack(input int exp_n);
    int n;
    n = 0;
    got_ack = 1'b0;
    while (!got_ack && n < 12) begin
      step();
      n++;
    end
    check("ack_latency", 32'(n), 32'(exp_n));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   32'(bus.ack),   32'd0);
    check({tag, "_err"},   32'(bus.err),   32'd0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_empty"}, 32'(bus.empty), 32'd1);
    check({tag, "_full"},  32'(bus.full),  32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  task automatic clear_inputs();
    bus.flush  = 1'b0;
    bus.req    = 2'b00;
    bus.op0    = 2'b00;
    bus.op1    = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // driver: one client operation, expected result queued at issue time
  task automatic run_op(input int c, input logic [1:0] op, input logic [DW-1:0] d,
                        input logic [DW-1:0] er, input logic ee, input int ec);
    @(negedge clk);
    if (c == 0) begin
      bus.op0 = op; bus.wdata0 = d;
    end else begin
      bus.op1 = op; bus.wdata1 = d;
    end
    bus.req[c] = 1'b1;
    exp_q.push_back({2'(1 << c), er, ee, 3'(ec)});
    wait_ack(3);
    step();
    bus.req[c] = 1'b0;
  endtask

  initial begin
    int c, t0;
    logic [1:0] op;
    logic [DW-1:0] d, er;
    logic ee;

    rst = 1'b0;
    clear_inputs();
    #1;
    check_idle_outputs("por");
    step();
    @(negedge clk);
    rst = 1'b1;

    // table: push/pop ordering, empty errors, illegal op, full error
    tbl[0]  = '{0, OP_PUSH, 18'd5,  18'd0,  1'b0, 1};
    tbl[1]  = '{0, OP_PUSH, 18'd9,  18'd0,  1'b0, 2};
    tbl[2]  = '{0, OP_PUSH, 18'd3,  18'd0,  1'b0, 3};
    tbl[3]  = '{0, OP_POP,  18'd0,  18'd3,  1'b0, 2};
    tbl[4]  = '{0, OP_POP,  18'd0,  18'd9,  1'b0, 1};
    tbl[5]  = '{0, OP_POP,  18'd0,  18'd5,  1'b0, 0};
    tbl[6]  = '{0, OP_POP,  18'd0,  18'd0,  1'b1, 0};
    tbl[7]  = '{0, OP_ILL,  18'd77, 18'd0,  1'b1, 0};
    tbl[8]  = '{1, OP_TOP,  18'd0,  18'd0,  1'b1, 0};
    tbl[9]  = '{1, OP_PUSH, 18'd11, 18'd0,  1'b0, 1};
    tbl[10] = '{0, OP_PUSH, 18'd22, 18'd0,  1'b0, 2};
    tbl[11] = '{1, OP_PUSH, 18'd33, 18'd0,  1'b0, 3};
    tbl[12] = '{0, OP_PUSH, 18'd44, 18'd0,  1'b0, 4};
    tbl[13] = '{1, OP_PUSH, 18'd7,  18'd0,  1'b1, 4};
    tbl[14] = '{0, OP_TOP,  18'd0,  18'd44, 1'b0, 4};
    tbl[15] = '{1, OP_ILL,  18'd5,  18'd0,  1'b1, 4};
    tbl[16] = '{1, OP_POP,  18'd0,  18'd44, 1'b0, 3};
    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].c, tbl[i].op, tbl[i].d, tbl[i].er, tbl[i].ee, tbl[i].ec);
    end

    // randomized operations against a reference stack
    do_reset();
    mcnt = 0;
    for (int i = 0; i < 24; i++) begin
      c  = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      d  = DW'($urandom_range(0, (1 << DW) - 1));
      er = '0;
      ee = 1'b0;
      case (op)
        OP_PUSH: if (mcnt == DEPTH) ee = 1'b1; else begin mm[mcnt] = d; mcnt++; end
        OP_POP:  if (mcnt == 0) ee = 1'b1; else begin mcnt--; er = mm[mcnt]; end
        OP_TOP:  if (mcnt == 0) ee = 1'b1; else er = mm[mcnt-1];
        default: ee = 1'b1;
      endcase
      run_op(c, op, d, er, ee, mcnt);
    end

    // both clients contend continuously: grants 0,1,0,1 every three cycles
    do_reset();
    @(negedge clk);
    bus.op0 = OP_PUSH; bus.wdata0 = 18'd100;
    bus.op1 = OP_PUSH; bus.wdata1 = 18'd200;
    bus.req = 2'b11;
    exp_q.push_back({2'b01, 18'd0, 1'b0, 3'd1});
    exp_q.push_back({2'b10, 18'd0, 1'b0, 3'd2});
    exp_q.push_back({2'b01, 18'd0, 1'b0, 3'd3});
    exp_q.push_back({2'b10, 18'd0, 1'b0, 3'd4});
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      got_ack = 1'b0;
      while (!got_ack && n < 12) begin
        step();
        n++;
      end
      check("rr_ack_cycle", 32'(cyc), 32'(t0 + 2 + 3 * k));
      step();
      bus.req[k % 2] = 1'b0;
      @(negedge clk);
      if (k == 0) begin bus.wdata0 = 18'd300; bus.req[0] = 1'b1; end
      if (k == 1) begin bus.wdata1 = 18'd400; bus.req[1] = 1'b1; end
    end
    run_op(1, OP_TOP, 18'd0, 18'd400, 1'b0, 4);
    run_op(0, OP_POP, 18'd0, 18'd400, 1'b0, 3);
    run_op(1, OP_POP, 18'd0, 18'd300, 1'b0, 2);

    // flush in IDLE wins over a pending request, which is served afterward
    do_reset();
    run_op(0, OP_PUSH, 18'd10, 18'd0, 1'b0, 1);
    run_op(0, OP_PUSH, 18'd20, 18'd0, 1'b0, 2);
    run_op(0, OP_PUSH, 18'd30, 18'd0, 1'b0, 3);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.op1   = OP_POP;
    bus.req[1] = 1'b1;
    exp_q.push_back({2'b10, 18'd0, 1'b1, 3'd0});
    step();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    wait_ack(3);
    step();
    bus.req[1] = 1'b0;

    // reset asserted while a PUSH is in EXEC: outputs clear at once, no ack
    run_op(0, OP_PUSH, 18'd9, 18'd0, 1'b0, 1);
    run_op(0, OP_TOP,  18'd0, 18'd9, 1'b0, 1);
    @(negedge clk);
    bus.op0 = OP_PUSH; bus.wdata0 = 18'd123; bus.req[0] = 1'b1;
    step();
    check("pre_rst_state", 32'(state_dbg), 32'(ST_EXEC));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    bus.req[0] = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    run_op(0, OP_PUSH, 18'd1, 18'd0, 1'b0, 1);
    run_op(1, OP_POP,  18'd0, 18'd1, 1'b0, 0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DATA_W, default 18, width of one stack entry (n, m, flag fields packed by the client).
REQ-002 Parameter DEPTH, default 16, number of stack entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous stack clear request.
REQ-006 req  input  2  per-client request; bit 0 = recursion controller, bit 1 = readback/debug client.
REQ-007 op0, op1  input  2 each  per-client operation: 01 PUSH, 10 POP, 11 TOP, 00 illegal.
REQ-008 wdata0, wdata1  input  DATA_W each  per-client push data.
REQ-009 ack  output  2  per-client one-cycle completion pulse.
REQ-010 rdata  output  DATA_W  entry returned by POP/TOP, valid while ack is high.
REQ-011 err  output  1  error flag for the completing operation, valid while ack is high.
REQ-012 count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 IDLE with flush=1: SHALL set count to 0, keep storage contents, ignore req, and stay in IDLE.
REQ-016 IDLE with flush=0 and any req bit set: SHALL latch the granted client, its op and its wdata, then go to EXEC.
REQ-017 Arbitration SHALL be round-robin: when both req bits are set, grant the client not served last; after reset, client 0 has priority.
REQ-018 EXEC PUSH, not full: SHALL write wdata to mem[count], increment count, and set rdata to 0.
REQ-019 EXEC POP, not empty: SHALL set rdata to mem[count-1] and decrement count.
REQ-020 EXEC TOP, not empty: SHALL set rdata to mem[count-1] and leave count unchanged.
REQ-021 Errors (PUSH when full, POP/TOP when empty, op 00): SHALL set err=1 and rdata=0, with no change to storage or count.
REQ-022 EXEC SHALL always go to RESP.
REQ-023 RESP SHALL pulse ack[grant] for exactly one cycle, record grant as last-served, and return to IDLE.
REQ-024 Latency: req sampled high at edge t SHALL give ack high during the cycle after edge t+2.
REQ-025 A client SHALL hold req, op and wdata stable until ack, then deassert req the next cycle; the block SHALL serve at most one operation per request.
REQ-026 flush during EXEC or RESP SHALL be ignored; the client holds flush until it observes empty=1.
REQ-027 full and empty SHALL be derived combinationally from registered count.
REQ-028 err and rdata SHALL be registered and SHALL hold their value outside ack cycles.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, count 0, ack 0, err 0, rdata 0, last-served = client 1.
REQ-030 Reset during EXEC or RESP SHALL abort the operation with no ack; storage contents are don't-care after reset.

Structure
REQ-031 Op encodings, state encoding, and default DATA_W/DEPTH SHALL live in a shared package (stack_pkg) used by the recursion controller and this block.
REQ-032 Storage SHALL be one sub-module, stack_mem: DEPTH x DATA_W registers, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-033 DEPTH=4; client 0 pushes 5, 9, 3, then POPs -> rdata 3, 9, 5 with err 0; count ends at 0, empty=1.
REQ-034 Four PUSHes, then a fifth PUSH of 7 -> err=1, count stays 4, full=1; a following TOP returns the fourth pushed value.
REQ-035 Both clients request in the same cycle, repeatedly -> grants alternate 0,1,0,1; each ack arrives exactly 2 cycles after its sample edge.
REQ-036 POP on empty, and op 00 -> err=1, rdata=0, count 0.
REQ-037 flush asserted in IDLE with count=3 while req[1] is high -> count 0 next cycle; req[1] is served afterward and its POP errors.
REQ-038 rst driven low mid-EXEC of a PUSH -> no ack, count 0, all outputs at reset values asynchronously; normal operation resumes after release.
